// File: rtl/triumph_mem_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// load/store requesters; one outstanding transaction, data-first with fetch anti-starvation.
module triumph_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Handshake: requester holds *_req_i until *_gnt_o; memory port holds
  // mem_req_o with a stable payload until mem_gnt_i, then answers once with mem_rvalid_i.
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                   owner_data_q, owner_data_d;
  logic                   pick_data;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]        mem_be_q, mem_be_d;
  logic                   if_gnt_q, if_gnt_d;
  logic                   d_gnt_q, d_gnt_d;
  logic                   if_rvalid_q, if_rvalid_d;
  logic                   d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]  d_rdata_q, d_rdata_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_data_d = owner_data_q;
    pick_data    = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
        pick_data = d_req_i && !(if_req_i && (starve_cnt_q == LIMIT));
        if (!if_req_i) starve_cnt_d = '0;
        if (d_req_i || if_req_i) begin
          state_d      = WAIT_GNT;
          mem_req_d    = 1'b1;
          owner_data_d = pick_data;
          if (pick_data) begin
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            mem_be_d    = d_be_i;
            if (if_req_i && (starve_cnt_q != LIMIT)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            if_gnt_d     = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr_i;
            mem_wdata_d  = '0;
            mem_be_d     = '1;
            starve_cnt_d = '0;
          end
        end
      end
      WAIT_GNT: begin
        if (mem_gnt_i) begin
          state_d   = WAIT_RSP;
          mem_req_d = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_data_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      owner_data_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_data_q <= owner_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_gnt_q     <= if_gnt_d;
      d_gnt_q      <= d_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign d_gnt_o     = d_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_triumph_mem_arbiter.sv
// Bench for triumph_mem_arbiter: directed vector table, reset/stray corner
// sequences, contention ordering and randomized traffic against a transaction model.
module tb_triumph_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  triumph_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_be_i(d_be), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          model_cnt = 0;       // times fetch has been passed over in a row
  logic [31:0] last_if_rdata = '0, last_d_rdata = '0;
  logic        seen_we;
  logic [3:0]  seen_be;
  int          rsp_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_gnts"}, {if_gnt, d_gnt}, 0);
    chk({tag, "_rvalids"}, {if_rvalid, d_rvalid}, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Reference arbitration: data first, but a fetch that has lost LIMIT
  // times in a row while waiting takes the next slot.
  task automatic predict(output bit exp_d);
    if (!d_req) exp_d = 1'b0;
    else if (!if_req) exp_d = 1'b1;
    else exp_d = (model_cnt < LIMIT);
    if (!if_req || !exp_d) model_cnt = 0;
    else model_cnt = model_cnt + 1;
  endtask

  // ---------------- driver: one transaction from IDLE ----------------
  task automatic do_txn(input int gdly, input int rdly, input logic [31:0] rdata,
                        input bit stray, output bit won_d);
    bit          exp_d;
    logic [31:0] e_addr, e_wdata, got, other;
    logic        e_we;
    logic [3:0]  e_be;
    predict(exp_d);
    won_d   = exp_d;
    e_we    = exp_d ? d_we : 1'b0;
    e_addr  = exp_d ? d_addr : if_addr;
    e_wdata = d_wdata;
    e_be    = exp_d ? d_be : 4'hF;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk("gnt_pulse", {if_gnt, d_gnt}, {!exp_d, exp_d});
    chk("req_busy_rise", {mem_req, busy}, 2'b11);
    chk("payload_we_addr", {mem_we, mem_addr}, {e_we, e_addr});
    chk("payload_be", mem_be, e_be);
    if (exp_d) chk("payload_wdata", mem_wdata, e_wdata);
    chk("no_early_rvalid", {if_rvalid, d_rvalid}, 0);
    seen_we = mem_we; seen_be = mem_be;
    if (exp_d) d_req = 1'b0; else if_req = 1'b0;
    for (int c = 0; c <= gdly; c++) begin
      if (c > 0) begin
        tick();
        chk("wait_gnt_req", {mem_req, busy, if_gnt, d_gnt}, 4'b1100);
        chk("wait_gnt_stable", {mem_we, mem_addr, mem_be}, {e_we, e_addr, e_be});
        chk("wait_gnt_no_rvalid", {if_rvalid, d_rvalid}, 0);
      end
      mem_gnt    = (c == gdly);
      mem_rvalid = stray && (c == 0) && (gdly > 0);
    end
    tick();
    chk("after_gnt_req_low", {mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid}, 6'b010000);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 0; c < rdly; c++) begin
      tick();
      chk("wait_rsp", {mem_req, busy, if_rvalid, d_rvalid}, 4'b0100);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    exp_q.push_back(rdata);
    tick();
    rsp_cyc = cyc_cnt;
    chk("rsp_route", {if_rvalid, d_rvalid}, {!exp_d, exp_d});
    chk("rsp_idle", {busy, mem_req}, 2'b00);
    got   = exp_d ? d_rdata : if_rdata;
    other = exp_d ? if_rdata : d_rdata;
    chk("rsp_rdata", got, exp_q.pop_front());
    chk("nonowner_rdata_hold", other, exp_d ? last_if_rdata : last_d_rdata);
    if (exp_d) last_d_rdata = rdata; else last_if_rdata = rdata;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gdly;
    int          rdly;
    logic [31:0] rdata;
    bit          stray;
    bit          exp_we;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit    won;
    int    prev_cyc;
    string ord;
    vecs[0] = '{1, 0, 32'h100, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF};
    vecs[1] = '{1, 1, 32'h200, 32'h12345678, 4'h3, 3, 1, 32'h0,        0, 1, 4'h3};
    vecs[2] = '{0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h00000013, 0, 0, 4'hF};
    vecs[3] = '{0, 0, 32'h4,   32'h0,        4'h0, 0, 0, 32'h00100093, 0, 0, 4'hF};
    vecs[4] = '{0, 0, 32'h8,   32'h0,        4'h0, 0, 0, 32'h00208113, 0, 0, 4'hF};
    vecs[5] = '{1, 0, 32'h340, 32'h0,        4'hF, 2, 2, 32'hCAFEF00D, 1, 0, 4'hF};

    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // stray response while idle
    mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("stray_idle", {if_rvalid, d_rvalid, busy, mem_req}, 0);
    chk("stray_idle_rdata", {if_rdata, d_rdata}, 0);

    prev_cyc = 0;
    foreach (vecs[i]) begin
      if (vecs[i].is_d) begin
        d_req = 1; d_we = vecs[i].we; d_addr = vecs[i].addr;
        d_wdata = vecs[i].wdata; d_be = vecs[i].be;
      end else begin
        if_req = 1; if_addr = vecs[i].addr;
      end
      do_txn(vecs[i].gdly, vecs[i].rdly, vecs[i].rdata, vecs[i].stray, won);
      chk("vec_owner", won, vecs[i].is_d);
      chk("vec_we", seen_we, vecs[i].exp_we);
      chk("vec_be", seen_be, vecs[i].exp_be);
      if (i == 3 || i == 4) chk("fetch_rvalid_spacing", rsp_cyc - prev_cyc, 3);
      prev_cyc = rsp_cyc;
    end

    // two contended grants leave the starvation count non-zero
    for (int k = 0; k < 2; k++) begin
      if_req = 1; d_req = 1; d_we = 0; if_addr = $urandom; d_addr = $urandom;
      do_txn(0, 0, $urandom, 0, won);
    end

    // reset while waiting for the response
    if_req = 1; d_req = 1; d_addr = 32'h500;
    predict(won);
    tick();
    chk("rst_seq_gnt", {if_gnt, d_gnt}, {!won, won});
    d_req = 0; mem_gnt = 1;
    tick();
    chk("rst_seq_wait_rsp", {mem_req, busy}, 2'b01);
    mem_gnt = 0; rst = 1; if_req = 0;
    tick();
    rst = 0;
    chk_reset_vals("rst_mid");
    mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_rvalid = 0;
    chk("rst_mid_no_rvalid", {if_rvalid, d_rvalid, busy, mem_req}, 0);
    model_cnt = 0; last_if_rdata = 0; last_d_rdata = 0;

    // continuous contention: fixed grant pattern
    ord = "";
    for (int k = 0; k < 10; k++) begin
      if_req = 1; d_req = 1; d_we = 1'($urandom_range(0, 1));
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      do_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom, 0, won);
      ord = {ord, won ? "D" : "I"};
    end
    checks++;
    if (ord != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL grant_order: got %s required DDDDIDDDDI", ord);
    end
    if_req = 0; d_req = 0;

    // randomized traffic; a losing requester keeps its request up
    for (int k = 0; k < 60; k++) begin
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1; if_addr = {$urandom_range(0, 255), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom);
      end
      if (!if_req && !d_req) begin
        model_cnt = 0;
        tick();
        chk("rand_idle", {busy, mem_req, if_gnt, d_gnt}, 0);
      end else begin
        do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
               1'($urandom_range(0, 1)), won);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
